ex_mul_unit: RTL and testbench

Iterative shift-add multiplier in the EX stage, directly downstream of the forwarding unit. It consumes the forwarded operand pair (fwS1_data, fwS2_data) for MUL instructions. While it works it holds the front of the pipeline with a stall, then presents a 32-bit result plus destination index toward the EX/M register. Operands are latched at accept because forwarded values can change while the pipeline is stalled.

---
 rtl/ex_mul_unit_pkg.sv | 13 +
 rtl/ex_mul_unit.sv | 102 ++++++++++
 tb/tb_ex_mul_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mul_unit_pkg.sv
// ex_mul_unit_pkg
//   Shared constants for the EX-stage iterative multiplier: FSM state
//   encoding, default operand width and register-index width.
package ex_mul_unit_pkg;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    localparam int MUL_WIDTH = 32;
    localparam int REG_IDX_W = 5;

endpackage

// File: rtl/ex_mul_unit.sv
// ex_mul_unit
//   Iterative shift-add multiplier sitting in EX behind the forwarding unit.
//   A MUL is accepted from IDLE, runs exactly WIDTH shift-add iterations in
//   BUSY while holding the front of the pipeline with mul_stall, then
//   presents the low WIDTH bits of the product for one cycle in DONE.
//
// Ports
//   clk                  in   clock, all state on rising edge
//   reset                in   synchronous active-high reset
//   mul_req_ID_EX_OUT    in   instruction in EX is a MUL
//   fwS1_data            in   forwarded multiplicand
//   fwS2_data            in   forwarded multiplier
//   rgD_index_ID_EX_OUT  in   destination register of the MUL in EX
//   flush                in   kill the instruction in EX
//   mul_stall            out  freeze PC, IF/ID, ID/EX; bubble into EX/M
//   mul_done             out  result valid this cycle
//   mul_result           out  low WIDTH bits of the product
//   mul_rgD_index        out  destination index latched at accept
//   mul_writeRg          out  register write enable (same as mul_done)
module ex_mul_unit
    import ex_mul_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mul_req_ID_EX_OUT,
    input  logic [WIDTH-1:0]     fwS1_data,
    input  logic [WIDTH-1:0]     fwS2_data,
    input  logic [REG_IDX_W-1:0] rgD_index_ID_EX_OUT,
    input  logic                 flush,
    output logic                 mul_stall,
    output logic                 mul_done,
    output logic [WIDTH-1:0]     mul_result,
    output logic [REG_IDX_W-1:0] mul_rgD_index,
    output logic                 mul_writeRg
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           state_reg, state_next;
    logic [WIDTH-1:0]     a_reg, b_reg, acc_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [REG_IDX_W-1:0] rd_reg;
    logic                 accept;

    assign accept = (state_reg == MUL_IDLE) && mul_req_ID_EX_OUT && !flush;

    // Flush kills whatever is in EX, so it wins over every state.
    // DONE always returns to IDLE: the MUL that produced the result is still
    // visible on mul_req_ID_EX_OUT in that cycle and must not restart.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = MUL_IDLE;
        end else begin
            case (state_reg)
                MUL_IDLE: if (accept) state_next = MUL_BUSY;
                MUL_BUSY: if (cnt_reg == CNT_LAST) state_next = MUL_DONE;
                MUL_DONE: state_next = MUL_IDLE;
                default:  state_next = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= MUL_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Operands are captured here because the forwarded values
                // may change while the pipeline is stalled.
                a_reg   <= fwS1_data;
                b_reg   <= fwS2_data;
                rd_reg  <= rgD_index_ID_EX_OUT;
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (state_reg == MUL_BUSY && !flush) begin
                // Fixed WIDTH iterations; no early exit when b runs out of ones.
                if (b_reg[0]) acc_reg <= acc_reg + a_reg;
                a_reg   <= a_reg << 1;
                b_reg   <= b_reg >> 1;
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Stall is combinational so the accepting cycle already freezes the front end.
    assign mul_stall     = !flush && (accept || state_reg == MUL_BUSY);
    assign mul_done      = !flush && (state_reg == MUL_DONE);
    assign mul_writeRg   = mul_done;
    assign mul_result    = acc_reg;
    assign mul_rgD_index = rd_reg;

endmodule

// File: tb/tb_ex_mul_unit.sv
module tb_ex_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mul_req_ID_EX_OUT;
    logic [31:0] fwS1_data;
    logic [31:0] fwS2_data;
    logic [4:0]  rgD_index_ID_EX_OUT;
    logic        flush;
    logic        mul_stall;
    logic        mul_done;
    logic [31:0] mul_result;
    logic [4:0]  mul_rgD_index;
    logic        mul_writeRg;

    int total = 0;
    int bad   = 0;

    ex_mul_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .mul_req_ID_EX_OUT   (mul_req_ID_EX_OUT),
        .fwS1_data           (fwS1_data),
        .fwS2_data           (fwS2_data),
        .rgD_index_ID_EX_OUT (rgD_index_ID_EX_OUT),
        .flush               (flush),
        .mul_stall           (mul_stall),
        .mul_done            (mul_done),
        .mul_result          (mul_result),
        .mul_rgD_index       (mul_rgD_index),
        .mul_writeRg         (mul_writeRg)
    );

    always #5 clk = ~clk;

    // One pipeline cycle: drive inputs mid-cycle, let combinational outputs settle.
    task automatic step(input logic req, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [4:0] rd, input logic fl, input logic rst);
        @(negedge clk);
        mul_req_ID_EX_OUT   = req;
        fwS1_data           = s1;
        fwS2_data           = s2;
        rgD_index_ID_EX_OUT = rd;
        flush               = fl;
        reset               = rst;
        #1;
    endtask

    // Accept one MUL with a single-cycle request (cycle 0), then observe 40 cycles.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input bit zero_ops, output logic [31:0] res, output logic [4:0] rdo,
                          output logic wr, output int done_cyc, output int stall_cnt,
                          output int done_cnt, output bit overlap);
        done_cyc = -1; stall_cnt = 0; done_cnt = 0; overlap = 1'b0;
        res = '0; rdo = '0; wr = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            if (c == 0) step(1'b1, a, b, rd, 1'b0, 1'b0);
            else if (zero_ops) step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
            else step(1'b0, a, b, rd, 1'b0, 1'b0);
            if (mul_stall) stall_cnt++;
            if (mul_stall && mul_done) overlap = 1'b1;
            if (mul_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; res = mul_result; rdo = mul_rgD_index; wr = mul_writeRg;
                end
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        total++; if (mul_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", mul_stall); end
        total++; if (mul_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", mul_done); end
        total++; if (mul_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", mul_result); end
        total++; if (mul_rgD_index !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", mul_rgD_index); end
        total++; if (mul_writeRg !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", mul_writeRg); end
        $display("reset: stall=%b done=%b result=%h rd=%0d", mul_stall, mul_done, mul_result, mul_rgD_index);
    endtask

    task automatic test_basic();
        logic [31:0] res; logic [4:0] rdo; logic wr; int dc, sc, dn; bit ov;
        do_mul(32'd7, 32'd6, 5'd5, 1'b0, res, rdo, wr, dc, sc, dn, ov);
        total++; if (dc !== 33) begin bad++; $display("FAIL basic_done_cycle got=%0d want=33", dc); end
        total++; if (sc !== 33) begin bad++; $display("FAIL basic_stall_cycles got=%0d want=33", sc); end
        total++; if (res !== 32'd42) begin bad++; $display("FAIL basic_result got=%0d want=42", res); end
        total++; if (rdo !== 5'd5) begin bad++; $display("FAIL basic_rd got=%0d want=5", rdo); end
        total++; if (wr !== 1'b1) begin bad++; $display("FAIL basic_writeRg got=%b want=1", wr); end
        total++; if (dn !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", dn); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL basic_stall_done_overlap got=%b want=0", ov); end
        $display("basic 7x6: done@%0d result=%0d rd=%0d stalls=%0d", dc, res, rdo, sc);
    endtask

    task automatic test_wrap();
        logic [31:0] res; logic [4:0] rdo; logic wr; int dc, sc, dn; bit ov;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, res, rdo, wr, dc, sc, dn, ov);
        total++; if (res !== 32'h0000_0001) begin bad++; $display("FAIL wrap_ones got=%h want=00000001", res); end
        total++; if (dc !== 33) begin bad++; $display("FAIL wrap_ones_cycle got=%0d want=33", dc); end
        $display("wrap ffffffff^2: result=%h done@%0d", res, dc);
        do_mul(32'h0001_0000, 32'h0001_0000, 5'd31, 1'b0, res, rdo, wr, dc, sc, dn, ov);
        total++; if (res !== 32'h0000_0000) begin bad++; $display("FAIL wrap_shift got=%h want=00000000", res); end
        total++; if (rdo !== 5'd31) begin bad++; $display("FAIL wrap_shift_rd got=%0d want=31", rdo); end
        $display("wrap 00010000^2: result=%h rd=%0d", res, rdo);
        do_mul(32'hDEAD_BEEF, 32'd1, 5'd1, 1'b0, res, rdo, wr, dc, sc, dn, ov);
        total++; if (res !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ident got=%h want=deadbeef", res); end
        $display("identity: result=%h", res);
    endtask

    task automatic test_hold();
        logic [31:0] res; logic [4:0] rdo; logic wr; int dc, sc, dn; bit ov;
        do_mul(32'd3, 32'd4, 5'd12, 1'b1, res, rdo, wr, dc, sc, dn, ov);
        total++; if (res !== 32'd12) begin bad++; $display("FAIL hold_result got=%0d want=12", res); end
        total++; if (rdo !== 5'd12) begin bad++; $display("FAIL hold_rd got=%0d want=12", rdo); end
        $display("hold 3x4 operands zeroed: result=%0d rd=%0d", res, rdo);
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [4:0] rdo; logic wr; int dc, sc, dn; bit ov;
        int early_done = 0;
        step(1'b1, 32'd3, 32'd5, 5'd4, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            step(1'b0, 32'd3, 32'd5, 5'd4, 1'b0, 1'b0);
            if (mul_done) early_done++;
        end
        step(1'b0, 32'd3, 32'd5, 5'd4, 1'b1, 1'b0);
        total++; if (mul_stall !== 1'b0) begin bad++; $display("FAIL flush_cycle_stall got=%b want=0", mul_stall); end
        total++; if (mul_done !== 1'b0) begin bad++; $display("FAIL flush_cycle_done got=%b want=0", mul_done); end
        step(1'b0, 32'd3, 32'd5, 5'd4, 1'b0, 1'b0);
        total++; if (mul_stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b want=0", mul_stall); end
        for (int c = 12; c <= 45; c++) begin
            step(1'b0, 32'd3, 32'd5, 5'd4, 1'b0, 1'b0);
            if (mul_done) early_done++;
        end
        total++; if (early_done !== 0) begin bad++; $display("FAIL flush_no_done got=%0d want=0", early_done); end
        do_mul(32'd2, 32'd2, 5'd3, 1'b0, res, rdo, wr, dc, sc, dn, ov);
        total++; if (res !== 32'd4) begin bad++; $display("FAIL flush_after_result got=%0d want=4", res); end
        total++; if (dc !== 33) begin bad++; $display("FAIL flush_after_cycle got=%0d want=33", dc); end
        $display("flush at 10: spurious dones=%0d, then 2x2=%0d done@%0d", early_done, res, dc);
    endtask

    task automatic test_reset_mid();
        int dn = 0, dc = -1;
        logic [31:0] res = '0; logic [4:0] rdo = '0;
        bit seen = 1'b0;
        step(1'b1, 32'd11, 32'd13, 5'd7, 1'b0, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            step(1'b1, 32'd11, 32'd13, 5'd7, 1'b0, 1'b0);
            if (mul_done) dn++;
        end
        step(1'b1, 32'd11, 32'd13, 5'd7, 1'b0, 1'b1);
        step(1'b1, 32'd11, 32'd13, 5'd7, 1'b0, 1'b0);
        total++; if (mul_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", mul_done); end
        total++; if (mul_result !== 32'd0) begin bad++; $display("FAIL rstmid_result got=%h want=0", mul_result); end
        total++; if (mul_rgD_index !== 5'd0) begin bad++; $display("FAIL rstmid_rd got=%0d want=0", mul_rgD_index); end
        total++; if (mul_writeRg !== 1'b0) begin bad++; $display("FAIL rstmid_wr got=%b want=0", mul_writeRg); end
        // Cycle 21 re-accepts; request stays high until the result appears.
        for (int c = 22; c <= 70; c++) begin
            step(seen ? 1'b0 : 1'b1, 32'd11, 32'd13, 5'd7, 1'b0, 1'b0);
            if (mul_done) begin
                dn++;
                if (!seen) begin seen = 1'b1; dc = c; res = mul_result; rdo = mul_rgD_index; end
            end
        end
        total++; if (dc !== 54) begin bad++; $display("FAIL rstmid_done_cycle got=%0d want=54", dc); end
        total++; if (res !== 32'd143) begin bad++; $display("FAIL rstmid_product got=%0d want=143", res); end
        total++; if (rdo !== 5'd7) begin bad++; $display("FAIL rstmid_rd_after got=%0d want=7", rdo); end
        total++; if (dn !== 1) begin bad++; $display("FAIL rstmid_done_count got=%0d want=1", dn); end
        $display("reset at 20: re-accept 11x13=%0d done@%0d dones=%0d", res, dc, dn);
    endtask

    task automatic test_back_to_back();
        int dn = 0, d1 = -1, d2 = -1;
        logic [31:0] r1 = '0, r2 = '0;
        logic [4:0] i1 = '0, i2 = '0;
        bit ov = 1'b0;
        for (int c = 0; c <= 75; c++) begin
            if (c <= 33) step(1'b1, 32'd5, 32'd5, 5'd1, 1'b0, 1'b0);
            else if (c <= 67) step(1'b1, 32'd9, 32'd9, 5'd2, 1'b0, 1'b0);
            else step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
            if (mul_stall && mul_done) ov = 1'b1;
            if (mul_done) begin
                dn++;
                if (dn == 1) begin d1 = c; r1 = mul_result; i1 = mul_rgD_index; end
                if (dn == 2) begin d2 = c; r2 = mul_result; i2 = mul_rgD_index; end
            end
        end
        total++; if (dn !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", dn); end
        total++; if (d1 !== 33) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=33", d1); end
        total++; if (d2 - d1 !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d want=34", d2 - d1); end
        total++; if (r1 !== 32'd25) begin bad++; $display("FAIL b2b_first_result got=%0d want=25", r1); end
        total++; if (r2 !== 32'd81) begin bad++; $display("FAIL b2b_second_result got=%0d want=81", r2); end
        total++; if (i1 !== 5'd1 || i2 !== 5'd2) begin bad++; $display("FAIL b2b_rd got=%0d,%0d want=1,2", i1, i2); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL b2b_overlap got=%b want=0", ov); end
        $display("back-to-back: 5x5=%0d @%0d, 9x9=%0d @%0d, dones=%0d", r1, d1, r2, d2, dn);
    endtask

    initial begin
        reset = 1'b1; mul_req_ID_EX_OUT = 1'b0; fwS1_data = '0; fwS2_data = '0;
        rgD_index_ID_EX_OUT = '0; flush = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
